// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizes and write-strobe encoding for the register-file writeback arbiter.
// The register file's write input is active-low, so WR_ON is a 0.
package regfile_wb_arbiter_pkg;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 8;
  localparam int CW   = 2;

  localparam logic WR_ON  = 1'b0;
  localparam logic WR_OFF = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester always wins; on contention
// the pointer picks the winner, and after any grant the pointer favours the other port.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // Granting port 0 hands priority to port 1, and vice versa.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (|gnt) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (port 0) and load unit (port 1),
// and tracks outstanding writes per register so decode can stall on pending operands.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW   = regfile_wb_arbiter_pkg::DW,
  parameter int AW   = regfile_wb_arbiter_pkg::AW,
  parameter int NREG = regfile_wb_arbiter_pkg::NREG,
  parameter int CW   = regfile_wb_arbiter_pkg::CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb0_valid,
  output logic            wb0_ready,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [DW-1:0]   wb0_data,
  input  logic            wb1_valid,
  output logic            wb1_ready,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [DW-1:0]   wb1_data,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_dst,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            rf_write,
  output logic [AW-1:0]   rf_writeAdd,
  output logic [DW-1:0]   rf_in,
  output logic [NREG-1:0] pending
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_accept;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_data;
  logic          w_commit;
  logic          w_issue;
  logic [CW-1:0] w_cnt [NREG];

  logic          r_rf_write;
  logic [AW-1:0] r_rf_writeAdd;
  logic [DW-1:0] r_rf_in;

  assign w_req = {wb1_valid, wb0_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign wb0_ready  = w_gnt[0];
  assign wb1_ready  = w_gnt[1];
  assign w_accept   = |w_gnt;
  assign w_win_addr = w_gnt[1] ? wb1_addr : wb0_addr;
  assign w_win_data = w_gnt[1] ? wb1_data : wb0_data;

  // Output register: an accepted write is presented for exactly one cycle and
  // committed by the register file on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rf_write    <= WR_OFF;
      r_rf_writeAdd <= '0;
      r_rf_in       <= '0;
    end else if (w_accept) begin
      r_rf_write    <= WR_ON;
      r_rf_writeAdd <= w_win_addr;
      r_rf_in       <= w_win_data;
    end else begin
      r_rf_write    <= WR_OFF;
    end
  end

  assign rf_write    = r_rf_write;
  assign rf_writeAdd = r_rf_writeAdd;
  assign rf_in       = r_rf_in;

  assign w_commit  = (r_rf_write == WR_ON);
  assign iss_ready = (w_cnt[iss_dst] != CNT_MAX);
  assign w_issue   = iss_valid & iss_ready;

  // One saturating outstanding-write counter per register. A same-edge issue and
  // commit cancel; a commit against an empty counter is ignored.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
      logic          w_inc;
      logic          w_dec;
      logic [CW-1:0] r_cnt;

      assign w_inc = w_issue  && (iss_dst == AW'(gi));
      assign w_dec = w_commit && (r_rf_writeAdd == AW'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
          r_cnt <= r_cnt + CW'(1);
        end else if (w_dec && !w_inc && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end

      assign w_cnt[gi]   = r_cnt;
      assign pending[gi] = |r_cnt;
    end
  endgenerate

  assign hazard1 = (w_cnt[rd_addr1] != '0);
  assign hazard2 = (w_cnt[rd_addr2] != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario tasks plus a randomized run, all checked against a transaction-level
// model of the arbiter, output register and per-register pending-write counts.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [AW-1:0]   wb0_addr, wb1_addr, iss_dst, rd_addr1, rd_addr2, rf_writeAdd;
  logic [DW-1:0]   wb0_data, wb1_data, rf_in;
  logic            iss_valid, iss_ready, hazard1, hazard2, rf_write;
  logic [NREG-1:0] pending;

  int vectors = 0;
  int miscompares = 0;

  // Model state: outstanding writes per register, preferred port, pending output write.
  int m_cnt [NREG];
  int m_ptr;
  bit m_wr;
  int m_addr;
  int m_data;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_dst(iss_dst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_write(rf_write), .rf_writeAdd(rf_writeAdd), .rf_in(rf_in), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    m_ptr = 0; m_wr = 0; m_addr = 0; m_data = 0;
  endfunction

  function automatic int m_winner();
    if (wb0_valid && wb1_valid) return m_ptr;
    if (wb0_valid) return 0;
    if (wb1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [NREG-1:0] m_pending();
    logic [NREG-1:0] p;
    for (int i = 0; i < NREG; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  // Advance the model by one edge using the inputs presented now, then clock the DUT.
  task automatic tick();
    int w;
    bit inc;
    w   = m_winner();
    inc = iss_valid && (m_cnt[int'(iss_dst)] != 3);
    if (!(inc && m_wr && (m_addr == int'(iss_dst)))) begin
      if (inc) m_cnt[int'(iss_dst)]++;
      if (m_wr && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
    end
    if (w >= 0) begin
      m_wr   = 1;
      m_addr = (w == 1) ? int'(wb1_addr) : int'(wb0_addr);
      m_data = (w == 1) ? int'(wb1_data) : int'(wb0_data);
      m_ptr  = 1 - w;
    end else begin
      m_wr = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 0; wb1_addr = '0; wb1_data = '0;
    iss_valid = 0; iss_dst = '0; rd_addr1 = '0; rd_addr2 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++; if (rf_write !== 1'b1) begin miscompares++; $display("FAIL reset_rf_write got %b want 1", rf_write); end
    vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL reset_pending got %h want 00", pending); end
    vectors++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %b%b want 00", hazard1, hazard2); end
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("FAIL reset_iss_ready got %b want 1", iss_ready); end
    vectors++; if (rf_writeAdd !== '0 || rf_in !== '0) begin miscompares++; $display("FAIL reset_rf_out got %0d/%h want 0/0000", rf_writeAdd, rf_in); end
  endtask

  task automatic test_single_write();
    apply_reset();
    iss_valid = 1; iss_dst = 3;
    tick();
    iss_valid = 0; rd_addr1 = 3;
    wb0_valid = 1; wb0_addr = 3; wb0_data = 16'hBEEF;
    #1;
    vectors++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready got %b%b want 01", wb1_ready, wb0_ready); end
    vectors++; if (hazard1 !== 1'b1 || pending !== 8'h08) begin miscompares++; $display("FAIL single_pre_hazard got %b/%h want 1/08", hazard1, pending); end
    tick();
    wb0_valid = 0;
    #1;
    vectors++; if (rf_write !== 1'b0 || rf_writeAdd !== 3'd3 || rf_in !== 16'hBEEF) begin miscompares++; $display("FAIL single_out got %b/%0d/%h want 0/3/beef", rf_write, rf_writeAdd, rf_in); end
    vectors++; if (hazard1 !== 1'b1) begin miscompares++; $display("FAIL single_hazard_during got %b want 1", hazard1); end
    tick();
    #1;
    vectors++; if (rf_write !== 1'b1 || rf_in !== 16'hBEEF) begin miscompares++; $display("FAIL single_after got %b/%h want 1/beef", rf_write, rf_in); end
    vectors++; if (hazard1 !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL single_clear got %b/%h want 0/00", hazard1, pending); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d0, d1;
    apply_reset();
    d0 = DW'($urandom); d1 = DW'($urandom);
    wb0_valid = 1; wb0_addr = 1; wb0_data = d0;
    wb1_valid = 1; wb1_addr = 2; wb1_data = d1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (wb0_ready !== (i % 2 == 0) || wb1_ready !== (i % 2 == 1)) begin miscompares++; $display("FAIL b2b_grant[%0d] got %b%b want %b%b", i, wb1_ready, wb0_ready, i % 2 == 1, i % 2 == 0); end
      tick();
      #1;
      vectors++; if (rf_write !== 1'b0 || rf_writeAdd !== AW'((i % 2 == 0) ? 1 : 2) || rf_in !== ((i % 2 == 0) ? d0 : d1)) begin
        miscompares++; $display("FAIL b2b_out[%0d] got %b/%0d/%h want 0/%0d/%h", i, rf_write, rf_writeAdd, rf_in, (i % 2 == 0) ? 1 : 2, (i % 2 == 0) ? d0 : d1);
      end
      if (i % 2 == 0) begin d0 = DW'($urandom); wb0_data = d0; end
      else begin d1 = DW'($urandom); wb1_data = d1; end
    end
    wb0_valid = 0; wb1_valid = 0;
    tick();
  endtask

  task automatic test_saturate();
    apply_reset();
    iss_valid = 1; iss_dst = 5;
    repeat (3) tick();
    rd_addr2 = 5;
    #1;
    vectors++; if (iss_ready !== 1'b0) begin miscompares++; $display("FAIL sat_ready5 got %b want 0", iss_ready); end
    vectors++; if (pending !== 8'h20 || hazard2 !== 1'b1) begin miscompares++; $display("FAIL sat_pending got %h/%b want 20/1", pending, hazard2); end
    iss_dst = 4;
    #1;
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("FAIL sat_ready4 got %b want 1", iss_ready); end
    iss_dst = 5;
    tick();
    iss_valid = 0;
    #1;
    vectors++; if (pending !== 8'h20) begin miscompares++; $display("FAIL sat_nowrap got %h want 20", pending); end
    wb1_valid = 1; wb1_addr = 5; wb1_data = 16'h0055;
    repeat (3) tick();
    wb1_valid = 0;
    #1;
    vectors++; if (pending !== 8'h20) begin miscompares++; $display("FAIL sat_partial got %h want 20", pending); end
    tick();
    #1;
    vectors++; if (pending !== 8'h00 || iss_ready !== 1'b1) begin miscompares++; $display("FAIL sat_drain got %h/%b want 00/1", pending, iss_ready); end
  endtask

  task automatic test_same_edge();
    apply_reset();
    iss_valid = 1; iss_dst = 6;
    tick();
    iss_valid = 0;
    wb0_valid = 1; wb0_addr = 6; wb0_data = 16'h6666;
    tick();
    wb0_valid = 0;
    iss_valid = 1; iss_dst = 6;
    #1;
    vectors++; if (rf_write !== 1'b0 || pending !== 8'h40) begin miscompares++; $display("FAIL same_pre got %b/%h want 0/40", rf_write, pending); end
    tick();
    iss_valid = 0;
    #1;
    vectors++; if (pending !== 8'h40) begin miscompares++; $display("FAIL same_edge got %h want 40", pending); end
    wb0_valid = 1;
    tick();
    wb0_valid = 0;
    tick();
    #1;
    vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL same_final got %h want 00", pending); end
  endtask

  task automatic test_underflow();
    apply_reset();
    wb0_valid = 1; wb0_addr = 7; wb0_data = 16'h7777;
    tick();
    wb0_valid = 0;
    tick();
    iss_dst = 7;
    #1;
    vectors++; if (pending !== 8'h00 || iss_ready !== 1'b1) begin miscompares++; $display("FAIL underflow got %h/%b want 00/1", pending, iss_ready); end
    iss_valid = 1;
    tick();
    iss_valid = 0;
    #1;
    vectors++; if (pending !== 8'h80) begin miscompares++; $display("FAIL underflow_issue got %h want 80", pending); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    iss_valid = 1; iss_dst = 2;
    tick();
    iss_valid = 0;
    wb1_valid = 1; wb1_addr = 2; wb1_data = 16'h1234;
    tick();
    wb1_valid = 0;
    #1;
    vectors++; if (rf_write !== 1'b0) begin miscompares++; $display("FAIL async_pre got %b want 0", rf_write); end
    #1 reset = 1'b0;
    #1;
    vectors++; if (rf_write !== 1'b1 || pending !== 8'h00) begin miscompares++; $display("FAIL async_reset got %b/%h want 1/00", rf_write, pending); end
    vectors++; if (rf_writeAdd !== '0 || rf_in !== '0) begin miscompares++; $display("FAIL async_out got %0d/%h want 0/0000", rf_writeAdd, rf_in); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit acc0, acc1;
    int w;
    apply_reset();
    acc0 = 0; acc1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!wb0_valid || acc0) begin wb0_valid = ($urandom_range(0, 2) != 0); wb0_addr = AW'($urandom); wb0_data = DW'($urandom); end
      if (!wb1_valid || acc1) begin wb1_valid = ($urandom_range(0, 2) != 0); wb1_addr = AW'($urandom); wb1_data = DW'($urandom); end
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_dst = AW'($urandom); rd_addr1 = AW'($urandom); rd_addr2 = AW'($urandom);
      #1;
      w = m_winner();
      vectors++; if (wb0_ready !== (w == 0) || wb1_ready !== (w == 1)) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b%b want winner %0d", n, wb1_ready, wb0_ready, w); end
      vectors++; if (iss_ready !== (m_cnt[int'(iss_dst)] != 3)) begin miscompares++; $display("FAIL rnd_iss_ready[%0d] got %b want cnt %0d", n, iss_ready, m_cnt[int'(iss_dst)]); end
      vectors++; if (hazard1 !== (m_cnt[int'(rd_addr1)] != 0) || hazard2 !== (m_cnt[int'(rd_addr2)] != 0)) begin miscompares++; $display("FAIL rnd_hazard[%0d] got %b%b", n, hazard1, hazard2); end
      vectors++; if (pending !== m_pending()) begin miscompares++; $display("FAIL rnd_pending[%0d] got %h want %h", n, pending, m_pending()); end
      vectors++; if (rf_write !== !m_wr || rf_writeAdd !== AW'(m_addr) || rf_in !== DW'(m_data)) begin
        miscompares++; $display("FAIL rnd_out[%0d] got %b/%0d/%h want %b/%0d/%h", n, rf_write, rf_writeAdd, rf_in, !m_wr, m_addr, DW'(m_data));
      end
      acc0 = (w == 0); acc1 = (w == 1);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_saturate();
    test_same_edge();
    test_underflow();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
